csa_accumulator: RTL
====================

# csa_accumulator

Multi-operand streaming accumulator built on carry-save compression. Each accepted beat carries up to LANES operands, which are folded into redundant sum/carry registers with no carry propagation on the accumulate path. On the final beat of a packet, one carry-propagate add resolves the total, which is presented behind a valid/ready handshake. The block sits in the arithmetic datapath wherever packet-length dot-product or checksum totals are needed at full clock rate.

## Interface
- WIDTH, 8, operand width in bits
- LANES, 3, operands per input beat (≥1)
- ACC_W, 16, accumulator and result width (≥ WIDTH)
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat
- in_data  in  LANES×WIDTH  packed operands; lane i = in_data[i*WIDTH +: WIDTH]
- in_keep  in  LANES  per-lane enable; a masked lane contributes 0
- in_last  in  1  beat is the last of the packet
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_sum  out  ACC_W  resolved packet total

## Operation
- States: ACC, RESOLVE, OUT.
- ACC: in_ready=1. Accept when in_valid&&in_ready.
  - Each kept lane is extended to ACC_W (zero-extend by default; see Configuration).
  - The LANES extended operands, sum_r, and carry_r are compressed to (s, c) by a 3:2 CSA tree.
  - Update: sum_r←s and carry_r←(c<<1) truncated to ACC_W.
  - If in_last, go to RESOLVE.
  - No accepted beat: registers hold.
- RESOLVE: in_ready=0. out_sum←(sum_r+carry_r) mod 2^ACC_W, computed from the already-updated registers. Clear sum_r and carry_r to 0. Go to OUT.
- OUT: in_ready=0, out_valid=1. out_sum is stable until out_valid&&out_ready, then go to ACC.
- A beat with in_keep=0 and in_last=1 is legal and closes the packet. A packet whose only beat is this one yields out_sum=0.
- Arithmetic is modulo 2^ACC_W. Wrap-around is silent and no overflow flag exists.
- The sum_r/carry_r invariant (sum_r+carry_r mod 2^ACC_W equals the running total) must hold after every accepted beat.
- Reset, including mid-packet or mid-OUT, discards the partial total:
  - state=ACC, sum_r=carry_r=0
  - out_valid=0, out_sum=0
  - after the reset edge, in_ready=1

## Timing
- Accumulate path has no carry propagation. The CSA tree depth is ⌈log1.5((LANES+2)/2)⌉ full-adder levels.
- If the last beat is accepted at edge t, the RESOLVE register update happens at edge t+1 and out_valid=1 from t+1.
- Fastest handshake: out_ready=1 at edge t+2 → in_ready=1 from t+2. Back-to-back packets therefore cost 2 idle input cycles.
- Non-last beats are accepted every cycle with no bubbles.
- in_ready and out_valid are decoded from registered state only, with no combinational path from in_valid or out_ready.

## Configuration
- CSA_SIGNED_EN defined: operands are two's-complement and sign-extended to ACC_W. out_sum is the two's-complement total mod 2^ACC_W.
- CSA_SIGNED_EN undefined: operands are unsigned and zero-extended.
- The macro affects only the extension logic. State machine and timing are identical in both builds.

## Structure
- csa_pkg holds:
  - the state enum csa_state_e (ACC, RESOLVE, OUT)
  - the default parameter constants
  - a function returning CSA tree depth for a given operand count
- Sub-module csa_tree #(N_OPS, W): purely combinational Wallace reduction of N_OPS W-bit operands to sum/carry. Its output carry is unshifted; the parent applies the shift. It is built from generic 3:2 rows (sum=a^b^c, carry=maj(a,b,c)).
- csa_accumulator contains the FSM, extension, registers, and final CPA.

## Test plan
- Default params, one beat {5,7,9}, keep=111, last=1, out_ready=1 → out_valid at t+1, out_sum=21, in_ready back to 1 at t+2.
- Three beats of {255,255,255}, last on beat 3, no stalls → out_sum=2295 (0x08F7). Check in_ready=1 on all three beats.
- One beat {10,20,30}, keep=101, last=1 → out_sum=40. Then a beat with keep=000, last=1 → out_sum=0.
- out_ready held low 5 cycles after out_valid rises → out_valid=1, out_sum stable, in_ready=0 throughout. Raise out_ready → one handshake, then in_ready=1.
- ACC_W=9: beat {255,255,255}, then {255,0,0} with last → out_sum=508 (1020 mod 512). Without CSA_SIGNED_EN, default params, {0xFF,0xFF,0x01} → 0x01FF. With CSA_SIGNED_EN, same input → 0xFFFF.
- rst asserted for 1 cycle after two non-last beats → out_valid=0, in_ready=1 after reset. Next packet {1,2,3}, last → out_sum=6, with no residue from before reset.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared types, default parameters and tree-sizing helpers for the carry-save accumulator.
package csa_pkg;

  typedef enum logic [1:0] {
    ACC     = 2'd0,
    RESOLVE = 2'd1,
    OUT     = 2'd2
  } csa_state_e;

  localparam int CSA_WIDTH = 8;
  localparam int CSA_LANES = 3;
  localparam int CSA_ACC_W = 16;

  // Operand count left after lvl rows of 3:2 compression; leftovers pass through.
  function automatic int csa_level_ops(input int n, input int lvl);
    int c;
    c = n;
    for (int i = 0; i < lvl; i++) begin
      if (c > 2) c = 2 * (c / 3) + (c % 3);
    end
    return c;
  endfunction

  function automatic int csa_depth(input int n);
    int c;
    int d;
    c = n;
    d = 0;
    while (c > 2) begin
      c = 2 * (c / 3) + (c % 3);
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/csa_tree.sv
// Combinational Wallace reduction of N_OPS words to a sum/carry pair (final carry unshifted).
module csa_tree
  import csa_pkg::*;
#(
  parameter int N_OPS = 5,
  parameter int W     = 16
) (
  input  logic [N_OPS*W-1:0] ops,
  output logic [W-1:0]       sum,
  output logic [W-1:0]       carry
);

  localparam int DEPTH = csa_depth(N_OPS);

  // Level-indexed operand slots; slots beyond a level's live count are tied to zero.
  logic [W-1:0] lv [0:DEPTH][0:N_OPS-1];

  genvar gi, gj;

  for (gj = 0; gj < N_OPS; gj++) begin : g_in
    assign lv[0][gj] = ops[gj*W +: W];
  end

  for (gi = 0; gi < DEPTH; gi++) begin : g_lvl
    localparam int N_IN  = csa_level_ops(N_OPS, gi);
    localparam int N_GRP = N_IN / 3;
    localparam int N_OUT = 2 * N_GRP + (N_IN % 3);
    localparam bit LAST  = (gi == DEPTH - 1);

    for (gj = 0; gj < N_OPS; gj++) begin : g_slot
      if (gj < 2 * N_GRP) begin : g_row
        localparam int G = gj / 2;
        logic [W-1:0] a, b, c, maj;
        assign a   = lv[gi][3*G];
        assign b   = lv[gi][3*G+1];
        assign c   = lv[gi][3*G+2];
        assign maj = (a & b) | (a & c) | (b & c);
        if (gj % 2 == 0) begin : g_sum
          assign lv[gi+1][gj] = a ^ b ^ c;
        end else if (LAST) begin : g_carry_raw
          assign lv[gi+1][gj] = maj;
        end else begin : g_carry_shift
          assign lv[gi+1][gj] = maj << 1;
        end
      end else if (gj < N_OUT) begin : g_pass
        // Output slot 2G+r carries input slot 3G+r.
        assign lv[gi+1][gj] = lv[gi][gj + N_GRP];
      end else begin : g_zero
        assign lv[gi+1][gj] = '0;
      end
    end
  end

  assign sum   = lv[DEPTH][0];
  assign carry = lv[DEPTH][1];

endmodule

// File: rtl/csa_accumulator.sv
// Streaming multi-operand accumulator: carry-save fold per beat, one CPA per packet.
// Define CSA_SIGNED_EN for two's-complement operands (sign extension); default is unsigned.
module csa_accumulator
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,
  parameter int LANES = CSA_LANES,
  parameter int ACC_W = CSA_ACC_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES-1:0]       in_keep,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_sum
);

  localparam int N_OPS = LANES + 2;

  csa_state_e         state_r;
  logic [ACC_W-1:0]   sum_r;
  logic [ACC_W-1:0]   carry_r;
  logic [ACC_W-1:0]   tree_s;
  logic [ACC_W-1:0]   tree_c;
  logic [N_OPS*ACC_W-1:0] tree_ops;

  genvar gi;

  for (gi = 0; gi < LANES; gi++) begin : g_lane
    logic [WIDTH-1:0] lane;
    logic [ACC_W-1:0] lane_ext;
    assign lane = in_data[gi*WIDTH +: WIDTH];
`ifdef CSA_SIGNED_EN
    assign lane_ext = ACC_W'($signed(lane));
`else
    assign lane_ext = ACC_W'(lane);
`endif
    assign tree_ops[gi*ACC_W +: ACC_W] = in_keep[gi] ? lane_ext : '0;
  end

  assign tree_ops[LANES*ACC_W +: ACC_W]     = sum_r;
  assign tree_ops[(LANES+1)*ACC_W +: ACC_W] = carry_r;

  csa_tree #(
    .N_OPS (N_OPS),
    .W     (ACC_W)
  ) u_tree (
    .ops   (tree_ops),
    .sum   (tree_s),
    .carry (tree_c)
  );

  // Handshake flags depend on state only, never on in_valid or out_ready.
  assign in_ready = (state_r == ACC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ACC;
      sum_r     <= '0;
      carry_r   <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else begin
      case (state_r)
        ACC: begin
          if (in_valid) begin
            sum_r   <= tree_s;
            carry_r <= tree_c << 1;
            if (in_last) state_r <= RESOLVE;
          end
        end
        RESOLVE: begin
          out_sum   <= sum_r + carry_r;
          sum_r     <= '0;
          carry_r   <= '0;
          out_valid <= 1'b1;
          state_r   <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= ACC;
          end
        end
        default: begin
          state_r   <= ACC;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
